unpacker_arbiter: RTL and testbench
===================================

// Module: unpacker_arbiter
// PURPOSE
//  Round-robin arbiter sharing one unpacker between NumReq packed-word producers (e.g. sensor lanes).
//  Grants one requester for a burst of BurstLen packed words, e.g. one image row, so rows never interleave.
//  Forwards granted data/valid to the unpacker input and reports the owner id for downstream demux.
//  Sits directly upstream of the unpacker, fed by per-lane FIFOs.
// PARAMETERS
//  NumReq        4      number of requesters (>=2)
//  PackedWidth   8      packed word width; matches the unpacker's packed_i
//  BurstLen      80     packed words per grant (>=1)
//  TimeoutCycles 256    stall limit in cycles; used only with UNPACKER_ARB_TIMEOUT_EN (>=1)
//  IdWidth       local  $clog2(NumReq)
// PORTS
//  clk_i          in   1                    clock
//  rst_i          in   1                    synchronous active-high reset
//  packed_i       in   NumReq*PackedWidth   requester words; req r at [r*PackedWidth +: PackedWidth]
//  valid_i        in   NumReq               per-requester valid
//  ready_o        out  NumReq               per-requester ready
//  packed_o       out  PackedWidth          to unpacker packed_i
//  valid_o        out  1                    to unpacker valid_i
//  ready_i        in   1                    from unpacker ready_o
//  grant_id_o     out  IdWidth              current/last owner id
//  busy_o         out  1                    1 while in GRANT
//  abort_o        out  1                    1-cycle pulse on timeout release (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, burst count 0, grant_id_o 0; valid_o, ready_o, busy_o, abort_o 0.
//  - FSM IDLE: if any valid_i, pick the first set bit scanning ptr, ptr+1, ... (mod NumReq).
//    Register it as grant_id; go to GRANT next cycle. Exactly one cycle of arbitration bubble.
//  - FSM GRANT: combinational pass-through of granted requester g:
//    packed_o = packed_i[g]; valid_o = valid_i[g]; ready_o[g] = ready_i; ready_o[other] = 0.
//    Zero-latency forwarding; fire = valid_i[g] & ready_i.
//  - Burst counter increments on fire; on fire with count == BurstLen-1: count -> 0, state -> IDLE, ptr -> g+1 mod NumReq.
//  - In IDLE, valid_o = 0 and all ready_o = 0; packed_o = 0 (datapath gated).
//  - grant_id_o holds the last owner through IDLE; it updates only on the IDLE->GRANT transition.
//  - Requester dropping valid mid-burst keeps the grant; arbiter waits (no timeout without macro).
//  - No requests in IDLE: stay IDLE, ptr unchanged.
//  - Single requester continuously valid: re-granted after a 1-cycle IDLE bubble.
//  - BurstLen == 1: every fire returns to IDLE.
//  - Reset mid-burst: immediate return to reset state; partial burst discarded, count cleared.
// CONFIGURATION
//  UNPACKER_ARB_TIMEOUT_EN defined:
//    - Stall counter clears on fire or state entry.
//    - It increments each GRANT cycle with valid_i[g] == 0.
//    - At TimeoutCycles: state -> IDLE, ptr -> g+1, count -> 0, abort_o = 1 for that cycle.
//    - ready_i stalls (valid high, ready low) never count.
//  UNPACKER_ARB_TIMEOUT_EN undefined: no stall counter; abort_o tied 0; grant held indefinitely.
// STRUCTURE
//  - Shared package unpacker_arb_pkg:
//    - typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e
//    - function rr_pick(req, ptr) returning the id plus a found flag
//  - Burst counter reuses counter_roll (max_val_i = BurstLen-1, up_i = fire).
//  - One natural sub-module: rr_priority_sel (combinational rotate / priority-encode / unrotate).
// TESTING
//  - Reset: hold rst_i 3 cycles with all valid_i=1 -> valid_o=0, ready_o=0, busy_o=0, grant_id_o=0.
//  - RR fairness: NumReq=4, BurstLen=2, all valid, ready_i=1 -> grant order 0,1,2,3,0.
//    Each burst is exactly 2 fires with a 1-cycle bubble between bursts.
//  - Skip: valid_i=4'b1010, ptr=0 -> grant 1, then 3, then 1; ready_o never asserted for 0 or 2.
//  - Backpressure: ready_i toggled randomly mid-burst -> packed_o stable while valid_o & !ready_i.
//    No word lost or duplicated; exactly BurstLen fires per grant.
//  - Mid-burst gap: granted req drops valid 10 cycles -> grant held, other valid reqs get ready_o=0.
//    With UNPACKER_ARB_TIMEOUT_EN and TimeoutCycles=4: abort_o pulses on the 4th stall cycle, next req granted.
//  - Reset mid-burst: rst_i after 3 of 8 fires -> next grant restarts at req 0 with count 0.

Source files
------------

// File: rtl/unpacker_arb_pkg.sv
// Shared types and round-robin pick helper for unpacker_arbiter.
package unpacker_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;

  localparam int MaxReq = 32;
  localparam int MaxIdW = 5;

  typedef struct packed {
    logic              found;
    logic [MaxIdW-1:0] id;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                       input logic [MaxIdW-1:0] ptr,
                                       input int                n);
    rr_pick_t res;
    int       idx;
    res = '0;
    for (int i = 0; i < MaxReq; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !res.found && req[idx[MaxIdW-1:0]]) begin
        res.found = 1'b1;
        res.id    = idx[MaxIdW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_roll.sv
// Up counter that rolls over to zero after reaching max_val_i.
module counter_roll #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             up_i,
  input  logic [Width-1:0] max_val_i,
  output logic [Width-1:0] count_o,
  output logic             wrap_o
);

  logic [Width-1:0] count_q, count_d;

  assign wrap_o  = up_i && (count_q == max_val_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (up_i) begin
      count_d = wrap_o ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/unpacker_arbiter_rr_priority_sel.sv
// Round-robin selector: rotate requests by ptr, priority-encode, unrotate.
module rr_priority_sel #(
  parameter int NumReq  = 4,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  output logic               found_o,
  output logic [IdWidth-1:0] id_o
);
  import unpacker_arb_pkg::*;

  localparam logic [IdWidth:0] NumReqW = (IdWidth+1)'(NumReq);

  logic [NumReq-1:0] rot;
  logic [MaxReq-1:0] rot_ext;
  rr_pick_t          pick;
  logic [IdWidth:0]  sum;
  logic [IdWidth:0]  unrot;
  logic              pick_unused;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_rot
    logic [IdWidth:0] raw;
    logic [IdWidth:0] wrapped;
    assign raw      = {1'b0, ptr_i} + (IdWidth+1)'(gi);
    assign wrapped  = (raw >= NumReqW) ? raw - NumReqW : raw;
    assign rot[gi]  = req_i[wrapped[IdWidth-1:0]];
  end

  always_comb begin
    rot_ext = '0;
    rot_ext[NumReq-1:0] = rot;
  end

  // Bit 0 of the rotated vector is the highest-priority requester.
  assign pick        = rr_pick(rot_ext, '0, NumReq);
  assign pick_unused = ^pick.id[MaxIdW-1:IdWidth];
  assign sum         = {1'b0, ptr_i} + {1'b0, pick.id[IdWidth-1:0]};
  assign unrot       = (sum >= NumReqW) ? sum - NumReqW : sum;
  assign id_o        = unrot[IdWidth-1:0];
  assign found_o     = pick.found;

endmodule

// File: rtl/unpacker_arbiter.sv
// Round-robin burst arbiter in front of a shared unpacker.
// Optional stall timeout enabled by defining UNPACKER_ARB_TIMEOUT_EN.
module unpacker_arbiter #(
  parameter int NumReq        = 4,
  parameter int PackedWidth   = 8,
  parameter int BurstLen      = 80,
  parameter int TimeoutCycles = 256,
  localparam int IdWidth      = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq*PackedWidth-1:0] packed_i,
  input  logic [NumReq-1:0]             valid_i,
  output logic [NumReq-1:0]             ready_o,
  output logic [PackedWidth-1:0]        packed_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [IdWidth-1:0]            grant_id_o,
  output logic                          busy_o,
  output logic                          abort_o
);
  import unpacker_arb_pkg::*;

  localparam int CntWidth = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam logic [CntWidth-1:0] BurstMax = CntWidth'(BurstLen - 1);
  localparam logic [IdWidth-1:0]  LastId   = IdWidth'(NumReq - 1);

  arb_state_e         state_q, state_d;
  logic [IdWidth-1:0] ptr_q, ptr_d;
  logic [IdWidth-1:0] gid_q, gid_d;
  logic               sel_found;
  logic [IdWidth-1:0] sel_id;
  logic               grant_valid, fire, burst_done, abort;
  logic [IdWidth-1:0] next_ptr;
  logic [CntWidth-1:0] burst_cnt_unused;

  rr_priority_sel #(.NumReq(NumReq), .IdWidth(IdWidth)) u_sel (
    .req_i   (valid_i),
    .ptr_i   (ptr_q),
    .found_o (sel_found),
    .id_o    (sel_id)
  );

  counter_roll #(.Width(CntWidth)) u_burst (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (abort),
    .up_i      (fire),
    .max_val_i (BurstMax),
    .count_o   (burst_cnt_unused),
    .wrap_o    (burst_done)
  );

  assign grant_valid = valid_i[gid_q];
  assign fire        = (state_q == ARB_GRANT) && grant_valid && ready_i;
  assign next_ptr    = (gid_q == LastId) ? '0 : gid_q + IdWidth'(1);
  assign grant_id_o  = gid_q;
  assign abort_o     = abort;

`ifdef UNPACKER_ARB_TIMEOUT_EN
  localparam int StallWidth = $clog2(TimeoutCycles + 1);
  localparam logic [StallWidth-1:0] StallMax = StallWidth'(TimeoutCycles - 1);

  logic [StallWidth-1:0] stall_q, stall_d;

  // Only an absent word counts as a stall; unpacker backpressure never does.
  assign abort = (state_q == ARB_GRANT) && !grant_valid && (stall_q == StallMax);

  always_comb begin
    stall_d = stall_q;
    if (state_q != ARB_GRANT || fire || abort) begin
      stall_d = '0;
    end else if (!grant_valid) begin
      stall_d = stall_q + StallWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  localparam int TimeoutUnused = TimeoutCycles;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    packed_o = '0;
    valid_o  = 1'b0;
    ready_o  = '0;
    busy_o   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          gid_d   = sel_id;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        busy_o         = 1'b1;
        packed_o       = packed_i[gid_q*PackedWidth +: PackedWidth];
        valid_o        = grant_valid;
        ready_o[gid_q] = ready_i;
        if (burst_done || abort) begin
          state_d = ARB_IDLE;
          ptr_d   = next_ptr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
    end
  end

endmodule

// File: tb/tb_unpacker_arbiter.sv
// Self-checking bench for unpacker_arbiter with a transaction-level reference model.
module tb_unpacker_arbiter;

  localparam int NR = 4;
  localparam int PW = 8;
  localparam int BL = 4;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [NR*PW-1:0] packed_i;
  logic [NR-1:0]    valid_i;
  logic [NR-1:0]    ready_o;
  logic [PW-1:0]    packed_o;
  logic             valid_o;
  logic             ready_i;
  logic [1:0]       grant_id_o;
  logic             busy_o;
  logic             abort_o;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the unpacker, where the next search starts,
  // words delivered in the current burst, consecutive missing-word cycles.
  bit m_busy;
  int m_owner, m_ptr, m_count, m_stall;

  logic          e_busy, e_valid, e_abort;
  logic [1:0]    e_gid;
  logic [NR-1:0] e_ready;
  logic [PW-1:0] e_packed;

  always #5 clk = ~clk;

  unpacker_arbiter #(
    .NumReq(NR), .PackedWidth(PW), .BurstLen(BL), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .packed_i(packed_i), .valid_i(valid_i),
    .ready_o(ready_o), .packed_o(packed_o), .valid_o(valid_o), .ready_i(ready_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .abort_o(abort_o)
  );

  task automatic release_grant();
    m_busy  = 1'b0;
    m_count = 0;
    m_stall = 0;
    m_ptr   = (m_owner + 1) % NR;
  endtask

  task automatic model_step();
    int idx;
    bit done;
    if (rst_i) begin
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_count = 0; m_stall = 0;
    end else if (!m_busy) begin
      done = 1'b0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!done && valid_i[idx]) begin
          m_busy = 1'b1; m_owner = idx; m_count = 0; m_stall = 0;
          done = 1'b1;
        end
      end
    end else if (valid_i[m_owner] && ready_i) begin
      m_count++;
      m_stall = 0;
      if (m_count == BL) release_grant();
    end else if (!valid_i[m_owner]) begin
`ifdef UNPACKER_ARB_TIMEOUT_EN
      m_stall++;
      if (m_stall == TO) release_grant();
`endif
    end
  endtask

  task automatic calc_expected();
    e_busy   = m_busy;
    e_gid    = m_owner[1:0];
    e_valid  = m_busy && valid_i[m_owner];
    e_ready  = '0;
    if (m_busy && ready_i) e_ready[m_owner] = 1'b1;
    e_packed = m_busy ? packed_i[m_owner*PW +: PW] : '0;
    e_abort  = 1'b0;
`ifdef UNPACKER_ARB_TIMEOUT_EN
    e_abort  = m_busy && !valid_i[m_owner] && (m_stall + 1 == TO);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; valid_i = '0; ready_i = 1'b0;
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = '1; ready_i = 1'b1; packed_i = $urandom();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      #1;
      checks++;
      if ({valid_o, ready_o, busy_o, grant_id_o, abort_o} !== 9'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got v=%b r=%b busy=%b gid=%0d abort=%b, expected all 0",
                 c, valid_o, ready_o, busy_o, grant_id_o, abort_o);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_rr_fairness();
    int            g;
    logic          eb;
    logic [NR-1:0] er;
    reset_dut();
    valid_i = '1; ready_i = 1'b1;
    for (int c = 0; c < 5 * (BL + 1); c++) begin
      packed_i = $urandom();
      #1;
      eb = (c % (BL + 1)) != 0;
      g  = (c / (BL + 1)) % NR;
      er = eb ? NR'(1 << g) : '0;
      checks++;
      if (busy_o !== eb || ready_o !== er || (eb && grant_id_o !== 2'(g))) begin
        errors++;
        $display("FAIL rr_fair cyc%0d: got busy=%b gid=%0d ready=%b, expected busy=%b gid=%0d ready=%b",
                 c, busy_o, grant_id_o, ready_o, eb, g, er);
      end
      if (eb && (c % (BL + 1)) == BL) $display("burst owner=%0d fires=%0d", grant_id_o, BL);
      next_cycle();
    end
  endtask

  task automatic test_skip();
    int            g;
    logic          eb;
    logic [NR-1:0] er;
    reset_dut();
    valid_i = 4'b1010; ready_i = 1'b1;
    for (int c = 0; c < 3 * (BL + 1); c++) begin
      packed_i = $urandom();
      #1;
      eb = (c % (BL + 1)) != 0;
      g  = ((c / (BL + 1)) % 2 == 1) ? 3 : 1;
      er = eb ? NR'(1 << g) : '0;
      checks++;
      if (busy_o !== eb || ready_o !== er || (eb && grant_id_o !== 2'(g))) begin
        errors++;
        $display("FAIL skip cyc%0d: got busy=%b gid=%0d ready=%b, expected busy=%b gid=%0d ready=%b",
                 c, busy_o, grant_id_o, ready_o, eb, g, er);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int            lane_seq[NR];
    int            exp_seq[NR];
    int            burst_fires;
    bit            prev_busy, prev_stall;
    logic [PW-1:0] prev_pk;
    logic [PW-1:0] want;
    logic [NR-1:0] accepted;
    reset_dut();
    for (int l = 0; l < NR; l++) begin lane_seq[l] = 0; exp_seq[l] = 0; end
    burst_fires = 0; prev_busy = 1'b0; prev_stall = 1'b0; prev_pk = '0;
    valid_i = '1;
    for (int c = 0; c < 150; c++) begin
      ready_i = 1'($urandom_range(0, 1));
      for (int l = 0; l < NR; l++) packed_i[l*PW +: PW] = {l[1:0], lane_seq[l][5:0]};
      #1;
      calc_expected();
      checks++;
      if ({busy_o, grant_id_o, valid_o, ready_o, packed_o} !== {e_busy, e_gid, e_valid, e_ready, e_packed}) begin
        errors++;
        $display("FAIL bp_outputs cyc%0d: got busy=%b gid=%0d v=%b r=%b pk=%h, expected busy=%b gid=%0d v=%b r=%b pk=%h",
                 c, busy_o, grant_id_o, valid_o, ready_o, packed_o, e_busy, e_gid, e_valid, e_ready, e_packed);
      end
      if (prev_stall) begin
        checks++;
        if (packed_o !== prev_pk) begin
          errors++;
          $display("FAIL bp_hold cyc%0d: got pk=%h, expected held pk=%h", c, packed_o, prev_pk);
        end
      end
      if (valid_o === 1'b1 && ready_i) begin
        want = {grant_id_o, exp_seq[grant_id_o][5:0]};
        checks++;
        if (packed_o !== want) begin
          errors++;
          $display("FAIL bp_word cyc%0d: got pk=%h, expected pk=%h", c, packed_o, want);
        end
        exp_seq[grant_id_o]++;
        burst_fires++;
      end
      if (prev_busy && busy_o === 1'b0) begin
        checks++;
        if (burst_fires != BL) begin
          errors++;
          $display("FAIL bp_burst_len cyc%0d: got %0d fires, expected %0d", c, burst_fires, BL);
        end
        $display("burst done fires=%0d", burst_fires);
        burst_fires = 0;
      end
      accepted   = ready_o & valid_i;
      prev_stall = (valid_o === 1'b1) && !ready_i;
      prev_pk    = packed_o;
      prev_busy  = (busy_o === 1'b1);
      next_cycle();
      for (int l = 0; l < NR; l++) if (accepted[l]) lane_seq[l]++;
    end
  endtask

  task automatic test_gap();
    reset_dut();
    valid_i = '1; ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      packed_i = $urandom();
      next_cycle();
    end
    for (int k = 0; k < 10; k++) begin
      valid_i = 4'b1110;
      packed_i = $urandom();
      #1;
`ifdef UNPACKER_ARB_TIMEOUT_EN
      if (k <= 3) begin
        checks++;
        if ({busy_o, grant_id_o, ready_o[3:1], abort_o} !== {1'b1, 2'd0, 3'b000, 1'(k == 3)}) begin
          errors++;
          $display("FAIL gap_timeout k%0d: got busy=%b gid=%0d r=%b abort=%b, expected busy=1 gid=0 r[3:1]=0 abort=%0d",
                   k, busy_o, grant_id_o, ready_o, abort_o, (k == 3));
        end
      end else if (k == 4) begin
        checks++;
        if (busy_o !== 1'b0) begin
          errors++;
          $display("FAIL gap_release k%0d: got busy=%b, expected 0", k, busy_o);
        end
      end else if (k == 5) begin
        checks++;
        if (busy_o !== 1'b1 || grant_id_o !== 2'd1) begin
          errors++;
          $display("FAIL gap_next k%0d: got busy=%b gid=%0d, expected busy=1 gid=1", k, busy_o, grant_id_o);
        end
      end
`else
      checks++;
      if ({busy_o, grant_id_o, valid_o, ready_o, abort_o} !== {1'b1, 2'd0, 1'b0, 4'b0001, 1'b0}) begin
        errors++;
        $display("FAIL gap_hold k%0d: got busy=%b gid=%0d v=%b r=%b abort=%b, expected busy=1 gid=0 v=0 r=0001 abort=0",
                 k, busy_o, grant_id_o, valid_o, ready_o, abort_o);
      end
`endif
      next_cycle();
    end
`ifndef UNPACKER_ARB_TIMEOUT_EN
    begin
      int fires0;
      int seen;
      fires0 = 0; seen = -1;
      valid_i = '1;
      for (int w = 0; w < 12; w++) begin
        packed_i = $urandom();
        #1;
        if (seen < 0 && busy_o === 1'b1 && grant_id_o !== 2'd0) seen = int'(grant_id_o);
        if (busy_o === 1'b1 && grant_id_o === 2'd0 && valid_o === 1'b1 && ready_i) fires0++;
        next_cycle();
      end
      checks++;
      if (seen != 1 || fires0 != BL - 1) begin
        errors++;
        $display("FAIL gap_resume: got next_gid=%0d remaining_fires=%0d, expected next_gid=1 remaining_fires=%0d",
                 seen, fires0, BL - 1);
      end
    end
`endif
  endtask

  task automatic test_reset_midburst();
    int f;
    reset_dut();
    valid_i = '1; ready_i = 1'b1;
    for (int c = 0; c < BL + 5; c++) begin
      packed_i = $urandom();
      #1;
      if (c == BL + 4) begin
        checks++;
        if (busy_o !== 1'b1 || grant_id_o !== 2'd1) begin
          errors++;
          $display("FAIL midburst_pre: got busy=%b gid=%0d, expected busy=1 gid=1", busy_o, grant_id_o);
        end
      end
      next_cycle();
    end
    rst_i = 1'b1;
    next_cycle();
    #1;
    checks++;
    if ({busy_o, grant_id_o, ready_o, valid_o} !== 8'b0) begin
      errors++;
      $display("FAIL midburst_reset: got busy=%b gid=%0d r=%b v=%b, expected all 0",
               busy_o, grant_id_o, ready_o, valid_o);
    end
    rst_i = 1'b0;
    f = 0;
    for (int w = 0; w < BL + 2; w++) begin
      packed_i = $urandom();
      #1;
      if (w == 1) begin
        checks++;
        if (busy_o !== 1'b1 || grant_id_o !== 2'd0) begin
          errors++;
          $display("FAIL midburst_regrant: got busy=%b gid=%0d, expected busy=1 gid=0", busy_o, grant_id_o);
        end
      end
      if (busy_o === 1'b1 && valid_o === 1'b1 && ready_i) f++;
      next_cycle();
    end
    checks++;
    if (f != BL) begin
      errors++;
      $display("FAIL midburst_count: got %0d fires, expected %0d", f, BL);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 300; c++) begin
      valid_i  = NR'($urandom()) | NR'($urandom());
      ready_i  = ($urandom_range(0, 3) != 0);
      packed_i = $urandom();
      #1;
      calc_expected();
      checks++;
      if ({busy_o, grant_id_o, valid_o, ready_o, packed_o, abort_o} !==
          {e_busy, e_gid, e_valid, e_ready, e_packed, e_abort}) begin
        errors++;
        $display("FAIL random cyc%0d: got busy=%b gid=%0d v=%b r=%b pk=%h ab=%b, expected busy=%b gid=%0d v=%b r=%b pk=%h ab=%b",
                 c, busy_o, grant_id_o, valid_o, ready_o, packed_o, abort_o,
                 e_busy, e_gid, e_valid, e_ready, e_packed, e_abort);
      end
      next_cycle();
    end
  endtask

  initial begin
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_count = 0; m_stall = 0;
    rst_i = 1'b1; valid_i = '0; ready_i = 1'b0; packed_i = '0;
    test_reset();
    test_rr_fairness();
    test_skip();
    test_backpressure();
    test_gap();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
